hex7seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode/cathode 7-segment display. It owns NDIG digit registers and shares a single hex-to-7-segment decoder between them, cycling through the digits with a programmable dwell time. Between digits it inserts a blanking gap so segments never ghost. It sits between the user-input logic of the tile and the dedicated output pins, replacing a static single-digit decode path.

---
 rtl/hex7seg_pkg.sv | 30 +++
 rtl/hex7seg_decode.sv | 32 +++
 rtl/hex7seg_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_hex7seg_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex7seg_pkg.sv
// Shared types and glyph constants for the hex 7-segment scan controller.
// Segment bit order: seg[0]=a ... seg[6]=g, active high.
package hex7seg_pkg;

    localparam int DIGIT_W = 5;  // {dp, hex[3:0]}

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex-to-7-segment decoder (0-9, A, b, C, d, E, F).
module hex7seg_decode
    import hex7seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // NOTE: all 16 codes have an arm and seg gets a default first, so no latch can be inferred.
    always_comb begin
        seg = SEG_0;
        unique case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex7seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display with blanking gaps.
// Optional macro LEADING_ZERO_BLANK_EN suppresses the glyphs of leading zero digits.
module hex7seg_scan_ctrl
    import hex7seg_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      wr_en,
    input  logic [$clog2(NDIG)-1:0]   wr_addr,
    input  logic [DIGIT_W-1:0]        wr_data,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NDIG-1:0]           dig,
    output logic                      frame_tick
);

    localparam int AW      = $clog2(NDIG);
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [AW-1:0] LAST_IDX   = AW'(NDIG - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);

    logic [DIGIT_W-1:0] digit_regs [NDIG];
    state_t             state;
    logic [AW-1:0]      idx;
    logic [CW-1:0]      cnt;
    logic [3:0]         latch_hex;
    logic [3:0]         dec_in;
    logic [6:0]         dec_seg;
    logic               show_entry;
    logic               lz_blank;

    // NOTE: the digit registers are cleared on reset because a reset must also wipe the displayed content.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) digit_regs[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < NDIG)) begin
            digit_regs[wr_addr] <= wr_data;
        end
    end

    // The decoder sees the register being latched on the entry edge, the latch afterwards,
    // so seg can be registered on the same edge as dig.
    assign show_entry = (state == ST_BLANK) && (cnt == '0);
    assign dec_in     = show_entry ? digit_regs[idx][3:0] : latch_hex;

    hex7seg_decode u_decode (
        .hex (dec_in),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = (idx != '0);
        for (int j = 0; j < NDIG; j++) begin
            if ((j >= int'(idx)) && (digit_regs[j][3:0] != 4'h0)) lz_blank = 1'b0;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    // NOTE: all state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            latch_hex  <= '0;
            seg        <= '0;
            dp         <= 1'b0;
            dig        <= '0;
            frame_tick <= 1'b0;
        end else if (!en) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            seg        <= '0;
            dp         <= 1'b0;
            dig        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    state <= ST_BLANK;
                    cnt   <= BLANK_LOAD;
                    seg   <= '0;
                    dp    <= 1'b0;
                    dig   <= '0;
                end
                ST_BLANK: begin
                    if (cnt == '0) begin
                        state      <= ST_SHOW;
                        cnt        <= DWELL_LOAD;
                        latch_hex  <= digit_regs[idx][3:0];
                        seg        <= lz_blank ? 7'h00 : dec_seg;
                        dp         <= digit_regs[idx][4];
                        dig        <= NDIG'(1) << idx;
                        frame_tick <= (DWELL == 1) && (idx == LAST_IDX);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == '0) begin
                        state <= ST_BLANK;
                        cnt   <= BLANK_LOAD;
                        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                        seg   <= '0;
                        dp    <= 1'b0;
                        dig   <= '0;
                    end else begin
                        cnt        <= cnt - 1'b1;
                        frame_tick <= (cnt == CW'(1)) && (idx == LAST_IDX);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex7seg_scan_ctrl.sv
// Self-checking bench for hex7seg_scan_ctrl with NDIG=4, DWELL=4, BLANK=2 (frame = 24 cycles).
module tb_hex7seg_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       frame_tick;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] data;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t       vecs [16];
    logic [6:0] frame_glyph [4];

    hex7seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .seg        (seg),
        .dp         (dp),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Steps at least once, then until dig equals target or the budget runs out.
    task automatic wait_dig(input logic [3:0] target, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while ((dig !== target) && (n < 100));
        if (dig !== target) begin
            tests++;
            failures++;
            $display("FAIL %s: timeout waiting for dig=%b, got %b", name, target, dig);
        end
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [4:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic check_off(input string name);
        check({name, "_dig"},  32'(dig),        32'h0);
        check({name, "_seg"},  32'(seg),        32'h0);
        check({name, "_dp"},   32'(dp),         32'h0);
        check({name, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{5'h0F, 7'h71, 1'b0};
        vecs[1]  = '{5'h10, 7'h3F, 1'b1};
        vecs[2]  = '{5'h01, 7'h06, 1'b0};
        vecs[3]  = '{5'h12, 7'h5B, 1'b1};
        vecs[4]  = '{5'h03, 7'h4F, 1'b0};
        vecs[5]  = '{5'h14, 7'h66, 1'b1};
        vecs[6]  = '{5'h05, 7'h6D, 1'b0};
        vecs[7]  = '{5'h16, 7'h7D, 1'b1};
        vecs[8]  = '{5'h07, 7'h07, 1'b0};
        vecs[9]  = '{5'h18, 7'h7F, 1'b1};
        vecs[10] = '{5'h09, 7'h6F, 1'b0};
        vecs[11] = '{5'h1A, 7'h77, 1'b1};
        vecs[12] = '{5'h0B, 7'h7C, 1'b0};
        vecs[13] = '{5'h1C, 7'h39, 1'b1};
        vecs[14] = '{5'h0D, 7'h5E, 1'b0};
        vecs[15] = '{5'h1E, 7'h79, 1'b1};
        frame_glyph[0] = 7'h06;
        frame_glyph[1] = 7'h5B;
        frame_glyph[2] = 7'h4F;
        frame_glyph[3] = 7'h66;

        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        check_off("reset");
        rst = 1'b0;
        step();
        check_off("idle_en_low");

        // First enable with all registers zero: blank for 2 cycles, then digit 0 shows "0".
        en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            check($sformatf("start_c%0d_dig", c), 32'(dig), (c >= 3) ? 32'h1 : 32'h0);
            check($sformatf("start_c%0d_seg", c), 32'(seg), (c >= 3) ? 32'h3F : 32'h0);
        end
        en = 1'b0;
        step();
        check_off("disable");

        // Full frame with digits 1,2,3,4.
        write_reg(2'd0, 5'h01);
        write_reg(2'd1, 5'h02);
        write_reg(2'd2, 5'h03);
        write_reg(2'd3, 5'h04);
        en = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            int  d;
            bit  lit;
            step();
            d   = (c - 1) / 6;
            lit = ((c - 1) % 6) >= 2;
            check($sformatf("frame_c%0d_dig", c), 32'(dig), lit ? (32'h1 << d) : 32'h0);
            check($sformatf("frame_c%0d_seg", c), 32'(seg), lit ? 32'(frame_glyph[d]) : 32'h0);
            check($sformatf("frame_c%0d_tick", c), 32'(frame_tick), (c == 24) ? 32'h1 : 32'h0);
        end

        // Write to digit 0 mid-dwell: old glyph holds, new one appears next frame.
        wait_dig(4'b0001, "wait_d0_mid");
        step();
        write_reg(2'd0, 5'h1A);
        check("mid_write_seg_a", 32'(seg), 32'h06);
        check("mid_write_dp_a",  32'(dp),  32'h0);
        step();
        check("mid_write_dig_b", 32'(dig), 32'h1);
        check("mid_write_seg_b", 32'(seg), 32'h06);
        wait_dig(4'b0001, "wait_d0_next");
        check("next_frame_seg", 32'(seg), 32'h77);
        check("next_frame_dp",  32'(dp),  32'h1);

        // Write landing exactly on the latch edge of digit 0.
        wait_dig(4'b1000, "wait_d3");
        wait_dig(4'b0000, "wait_gap");
        step();
        write_reg(2'd0, 5'h03);
        check("latch_write_dig", 32'(dig), 32'h1);
        check("latch_write_seg", 32'(seg), 32'h77);
        check("latch_write_dp",  32'(dp),  32'h1);
        wait_dig(4'b0000, "wait_gap2");
        wait_dig(4'b0001, "wait_d0_after_latch");
        check("after_latch_seg", 32'(seg), 32'h4F);
        check("after_latch_dp",  32'(dp),  32'h0);

        // Drop en mid-SHOW of digit 2, then restart from digit 0 with a full blank.
        wait_dig(4'b0100, "wait_d2");
        step();
        en = 1'b0;
        step();
        check_off("en_drop");
        en = 1'b1;
        step();
        check("reen_c1_dig", 32'(dig), 32'h0);
        step();
        check("reen_c2_dig", 32'(dig), 32'h0);
        step();
        check("reen_c3_dig", 32'(dig), 32'h1);
        check("reen_c3_seg", 32'(seg), 32'h4F);

        // Decode sweep on digit 3.
        for (int i = 0; i < 16; i++) begin
            write_reg(2'd3, vecs[i].data);
            wait_dig(4'b0000, "sweep_gap");
            wait_dig(4'b1000, "sweep_d3");
            check($sformatf("sweep_%0h_seg", vecs[i].data[3:0]), 32'(seg), 32'(vecs[i].seg));
            check($sformatf("sweep_%0h_dp", vecs[i].data[3:0]),  32'(dp),  32'(vecs[i].dp));
        end

        // Leading zeros: digits 3..0 = 0,0,5,0.
        en = 1'b0;
        step();
        write_reg(2'd3, 5'h00);
        write_reg(2'd2, 5'h00);
        write_reg(2'd1, 5'h05);
        write_reg(2'd0, 5'h00);
        en = 1'b1;
        wait_dig(4'b0001, "lz_d0");
        check("lz_d0_seg", 32'(seg), 32'h3F);
        wait_dig(4'b0010, "lz_d1");
        check("lz_d1_seg", 32'(seg), 32'h6D);
        wait_dig(4'b0100, "lz_d2");
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_d2_seg", 32'(seg), 32'h00);
`else
        check("lz_d2_seg", 32'(seg), 32'h3F);
`endif
        wait_dig(4'b1000, "lz_d3");
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_d3_seg", 32'(seg), 32'h00);
`else
        check("lz_d3_seg", 32'(seg), 32'h3F);
`endif

        // Reset mid-scan clears the registers: digit 1 (was 5) now shows "0".
        wait_dig(4'b0010, "rst_wait_d1");
        rst = 1'b1;
        step();
        check_off("mid_reset");
        rst = 1'b0;
        wait_dig(4'b0010, "post_rst_d1");
        check("post_rst_d1_seg", 32'(seg), 32'h3F);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
